// File: rtl/execution_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execution_pkg : shared encodings for the execution stage | rev 1.0
// ----------------------------------------------------------------------------
package execution_pkg;

  // Multiply/divide operation encodings
  localparam logic [2:0] c_MD_NONE  = 3'd0;
  localparam logic [2:0] c_MD_MULT  = 3'd1;
  localparam logic [2:0] c_MD_MULTU = 3'd2;
  localparam logic [2:0] c_MD_DIV   = 3'd3;
  localparam logic [2:0] c_MD_DIVU  = 3'd4;
  localparam logic [2:0] c_MD_MFHI  = 3'd5;
  localparam logic [2:0] c_MD_MFLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  // LO after a divide by zero is this bit replicated across the datapath
  localparam logic c_DIV0_LO_FILL = 1'b1;

  // ALU operation classes decoded from ID
  localparam logic [2:0] c_AOP_RTYPE = 3'd0;
  localparam logic [2:0] c_AOP_ADD   = 3'd1;
  localparam logic [2:0] c_AOP_AND   = 3'd2;
  localparam logic [2:0] c_AOP_OR    = 3'd3;
  localparam logic [2:0] c_AOP_XOR   = 3'd4;
  localparam logic [2:0] c_AOP_LUI   = 3'd5;
  localparam logic [2:0] c_AOP_SLT   = 3'd6;
  localparam logic [2:0] c_AOP_SUB   = 3'd7;

  // ALU function codes
  localparam logic [3:0] c_ALU_SLL  = 4'd0;
  localparam logic [3:0] c_ALU_SRL  = 4'd1;
  localparam logic [3:0] c_ALU_SRA  = 4'd2;
  localparam logic [3:0] c_ALU_ADD  = 4'd3;
  localparam logic [3:0] c_ALU_SUB  = 4'd4;
  localparam logic [3:0] c_ALU_AND  = 4'd5;
  localparam logic [3:0] c_ALU_OR   = 4'd6;
  localparam logic [3:0] c_ALU_XOR  = 4'd7;
  localparam logic [3:0] c_ALU_NOR  = 4'd8;
  localparam logic [3:0] c_ALU_SLT  = 4'd9;
  localparam logic [3:0] c_ALU_SLTU = 4'd10;
  localparam logic [3:0] c_ALU_LUI  = 4'd11;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu : combinational integer ALU | rev 1.0
// ----------------------------------------------------------------------------
module alu
  import execution_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [3:0]         i_alu_control,
  output logic [NB_DATA-1:0] o_result
);

  localparam int SHW = $clog2(NB_DATA);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_a[SHW-1:0];

  always_comb begin
    o_result = '0;
    case (i_alu_control)
      c_ALU_SLL:  o_result = i_b << w_shamt;
      c_ALU_SRL:  o_result = i_b >> w_shamt;
      c_ALU_SRA:  o_result = $signed(i_b) >>> w_shamt;
      c_ALU_ADD:  o_result = i_a + i_b;
      c_ALU_SUB:  o_result = i_a - i_b;
      c_ALU_AND:  o_result = i_a & i_b;
      c_ALU_OR:   o_result = i_a | i_b;
      c_ALU_XOR:  o_result = i_a ^ i_b;
      c_ALU_NOR:  o_result = ~(i_a | i_b);
      c_ALU_SLT:  o_result = {{(NB_DATA-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      c_ALU_SLTU: o_result = {{(NB_DATA-1){1'b0}}, (i_a < i_b)};
      c_ALU_LUI:  o_result = i_b << (NB_DATA/2);
      default:    o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_control : maps alu_operation class and funct to an ALU code | rev 1.0
// ----------------------------------------------------------------------------
module alu_control
  import execution_pkg::*;
#(
  parameter int NB_OP_FIELD     = 6,
  parameter int NB_ALU_OP_FIELD = 3
) (
  input  logic [NB_OP_FIELD-1:0]     i_funct,
  input  logic [NB_ALU_OP_FIELD-1:0] i_alu_operation,
  output logic [3:0]                 o_alu_control
);

  always_comb begin
    o_alu_control = c_ALU_ADD;
    case (i_alu_operation)
      c_AOP_RTYPE: begin
        // Variable shifts share the immediate-shift codes; the operand mux picks the amount
        case (i_funct)
          6'h00, 6'h04: o_alu_control = c_ALU_SLL;
          6'h02, 6'h06: o_alu_control = c_ALU_SRL;
          6'h03, 6'h07: o_alu_control = c_ALU_SRA;
          6'h20, 6'h21: o_alu_control = c_ALU_ADD;
          6'h22, 6'h23: o_alu_control = c_ALU_SUB;
          6'h24:        o_alu_control = c_ALU_AND;
          6'h25:        o_alu_control = c_ALU_OR;
          6'h26:        o_alu_control = c_ALU_XOR;
          6'h27:        o_alu_control = c_ALU_NOR;
          6'h2A:        o_alu_control = c_ALU_SLT;
          6'h2B:        o_alu_control = c_ALU_SLTU;
          default:      o_alu_control = c_ALU_ADD;
        endcase
      end
      c_AOP_ADD: o_alu_control = c_ALU_ADD;
      c_AOP_AND: o_alu_control = c_ALU_AND;
      c_AOP_OR:  o_alu_control = c_ALU_OR;
      c_AOP_XOR: o_alu_control = c_ALU_XOR;
      c_AOP_LUI: o_alu_control = c_ALU_LUI;
      c_AOP_SLT: o_alu_control = c_ALU_SLT;
      c_AOP_SUB: o_alu_control = c_ALU_SUB;
      default:   o_alu_control = c_ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_iterative.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_iterative : one-bit-per-cycle multiply/divide with HI/LO | rev 1.0
// ----------------------------------------------------------------------------
module muldiv_iterative
  import execution_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_MD_OP = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_MD_OP-1:0] i_op,
  input  logic [NB_DATA-1:0]  i_a,
  input  logic [NB_DATA-1:0]  i_b,
  output logic                o_busy,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo
);

  localparam int CNT_W = $clog2(NB_DATA + 1);

  md_state_e            r_state;
  logic [CNT_W-1:0]     r_count;
  // r_acc: product accumulator (MUL) / partial remainder in low half (DIV)
  // r_opb: shifting multiplicand (MUL) / divisor in low half (DIV)
  // r_q:   multiplier shifted right (MUL) / dividend-in, quotient-out (DIV)
  logic [2*NB_DATA-1:0] r_acc;
  logic [2*NB_DATA-1:0] r_opb;
  logic [NB_DATA-1:0]   r_q;
  logic [NB_DATA-1:0]   r_hi;
  logic [NB_DATA-1:0]   r_lo;
  logic                 r_neg;
  logic                 r_rem_neg;
  logic                 r_div0;

  logic                 w_signed, w_is_div, w_a_neg, w_b_neg, w_ge;
  logic [NB_DATA-1:0]   w_a_mag, w_b_mag, w_diff, w_rem_next, w_quo_next;
  logic [2*NB_DATA-1:0] w_acc_next, w_prod;
  logic [NB_DATA:0]     w_shift;

  assign w_signed = (i_op == c_MD_MULT) || (i_op == c_MD_DIV);
  assign w_is_div = (i_op == c_MD_DIV)  || (i_op == c_MD_DIVU);
  assign w_a_neg  = w_signed & i_a[NB_DATA-1];
  assign w_b_neg  = w_signed & i_b[NB_DATA-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  assign w_acc_next = r_q[0] ? (r_acc + r_opb) : r_acc;
  assign w_prod     = r_neg ? -w_acc_next : w_acc_next;

  // Restoring step; a zero divisor always "fits", giving all-ones quotient and rem = |a|
  assign w_shift    = {r_acc[NB_DATA-1:0], r_q[NB_DATA-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opb[NB_DATA-1:0]});
  assign w_diff     = w_shift[NB_DATA-1:0] - r_opb[NB_DATA-1:0];
  assign w_rem_next = w_ge ? w_diff : w_shift[NB_DATA-1:0];
  assign w_quo_next = {r_q[NB_DATA-2:0], w_ge};

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_q       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state   <= w_is_div ? ST_DIV : ST_MUL;
            r_count   <= CNT_W'(NB_DATA);
            r_acc     <= '0;
            r_opb     <= {{NB_DATA{1'b0}}, (w_is_div ? w_b_mag : w_a_mag)};
            r_q       <= w_is_div ? w_a_mag : w_b_mag;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_div0    <= (i_b == '0);
          end
        end
        ST_MUL: begin
          r_count <= r_count - CNT_W'(1);
          r_acc   <= w_acc_next;
          r_opb   <= r_opb << 1;
          r_q     <= r_q >> 1;
          if (r_count == CNT_W'(1)) begin
            r_hi    <= w_prod[2*NB_DATA-1:NB_DATA];
            r_lo    <= w_prod[NB_DATA-1:0];
            r_state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          r_count <= r_count - CNT_W'(1);
          r_acc   <= {{NB_DATA{1'b0}}, w_rem_next};
          r_q     <= w_quo_next;
          if (r_count == CNT_W'(1)) begin
            r_lo    <= r_div0 ? {NB_DATA{c_DIV0_LO_FILL}}
                              : (r_neg ? -w_quo_next : w_quo_next);
            r_hi    <= r_rem_neg ? -w_rem_next : w_rem_next;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
`default_nettype wire

// File: rtl/execution_md.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execution_md : EX stage with EX/MEM register and iterative mul/div | rev 1.0
// ----------------------------------------------------------------------------
module execution_md
  import execution_pkg::*;
#(
  parameter int NB_DATA         = 32,
  parameter int NB_REG_ADDRESS  = 5,
  parameter int NB_OP_FIELD     = 6,
  parameter int NB_ALU_OP_FIELD = 3,
  parameter int NB_MD_OP        = 3
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_valid,
  input  logic                       i_hold,
  input  logic                       i_shift_source,
  input  logic                       i_register_destination,
  input  logic                       i_alu_source,
  input  logic [NB_ALU_OP_FIELD-1:0] i_alu_operation,
  input  logic [NB_MD_OP-1:0]        i_md_operation,
  input  logic                       i_reg_write,
  input  logic [NB_DATA-1:0]         i_ra_data,
  input  logic [NB_DATA-1:0]         i_rb_data,
  input  logic [NB_DATA-1:0]         i_sign_extender_data,
  input  logic [NB_REG_ADDRESS-1:0]  i_rt_address,
  input  logic [NB_REG_ADDRESS-1:0]  i_rd_address,
  output logic                       o_stall,
  output logic                       o_busy,
  output logic                       o_valid,
  output logic                       o_reg_write,
  output logic [NB_REG_ADDRESS-1:0]  o_register_address,
  output logic [NB_DATA-1:0]         o_alu_result,
  output logic [NB_DATA-1:0]         o_memory_data
);

  logic                      w_busy, w_md_arith, w_mf, w_accept;
  logic [3:0]                w_alu_control;
  logic [NB_DATA-1:0]        w_op_a, w_op_b, w_alu_result, w_result, w_hi, w_lo;
  logic [NB_REG_ADDRESS-1:0] w_dest;

  logic                      r_valid, r_reg_write;
  logic [NB_REG_ADDRESS-1:0] r_register_address;
  logic [NB_DATA-1:0]        r_alu_result, r_memory_data;

  assign w_md_arith = (i_md_operation >= c_MD_MULT) && (i_md_operation <= c_MD_DIVU);
  assign w_mf       = (i_md_operation == c_MD_MFHI) || (i_md_operation == c_MD_MFLO);

  // Only HI/LO users wait on the unit; plain ALU ops flow past it
  assign o_stall  = w_busy & i_valid & (i_md_operation != c_MD_NONE);
  assign w_accept = i_valid & ~o_stall & ~i_hold;
  assign o_busy   = w_busy;

  assign w_op_a = i_shift_source ? {{(NB_DATA-5){1'b0}}, i_sign_extender_data[10:6]} : i_ra_data;
  assign w_op_b = i_alu_source ? i_sign_extender_data : i_rb_data;
  assign w_dest = (w_mf || !i_register_destination) ? i_rd_address : i_rt_address;

  alu_control #(
    .NB_OP_FIELD     (NB_OP_FIELD),
    .NB_ALU_OP_FIELD (NB_ALU_OP_FIELD)
  ) u_alu_control (
    .i_funct         (i_sign_extender_data[NB_OP_FIELD-1:0]),
    .i_alu_operation (i_alu_operation),
    .o_alu_control   (w_alu_control)
  );

  alu #(
    .NB_DATA (NB_DATA)
  ) u_alu (
    .i_a           (w_op_a),
    .i_b           (w_op_b),
    .i_alu_control (w_alu_control),
    .o_result      (w_alu_result)
  );

  muldiv_iterative #(
    .NB_DATA  (NB_DATA),
    .NB_MD_OP (NB_MD_OP)
  ) u_muldiv (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (w_accept & w_md_arith),
    .i_op    (i_md_operation),
    .i_a     (i_ra_data),
    .i_b     (i_rb_data),
    .o_busy  (w_busy),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  always_comb begin
    w_result = w_alu_result;
    if (i_md_operation == c_MD_MFHI)
      w_result = w_hi;
    else if (i_md_operation == c_MD_MFLO)
      w_result = w_lo;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_valid            <= 1'b0;
      r_reg_write        <= 1'b0;
      r_register_address <= '0;
      r_alu_result       <= '0;
      r_memory_data      <= '0;
    end else if (!i_hold) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_reg_write        <= i_reg_write & ~w_md_arith;
        r_register_address <= w_dest;
        r_alu_result       <= w_result;
        r_memory_data      <= i_rb_data;
      end
    end
  end

  assign o_valid            = r_valid;
  assign o_reg_write        = r_reg_write;
  assign o_register_address = r_register_address;
  assign o_alu_result       = r_alu_result;
  assign o_memory_data      = r_memory_data;

endmodule
`default_nettype wire

// File: tb/tb_execution_md.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_execution_md : directed scoreboard bench for execution_md | rev 1.0
// ----------------------------------------------------------------------------
module tb_execution_md;
  import execution_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, vld, hold, sh, dst, src, regw;
  logic [2:0]  aop, md;
  logic [31:0] ra, rb, imm;
  logic [4:0]  rt, rd;
  logic        o_stall, o_busy, o_valid, o_reg_write;
  logic [4:0]  o_register_address;
  logic [31:0] o_alu_result, o_memory_data;

  always #5 clk = ~clk;

  execution_md dut (
    .i_clock                (clk),
    .i_reset                (rst_n),
    .i_valid                (vld),
    .i_hold                 (hold),
    .i_shift_source         (sh),
    .i_register_destination (dst),
    .i_alu_source           (src),
    .i_alu_operation        (aop),
    .i_md_operation         (md),
    .i_reg_write            (regw),
    .i_ra_data              (ra),
    .i_rb_data              (rb),
    .i_sign_extender_data   (imm),
    .i_rt_address           (rt),
    .i_rd_address           (rd),
    .o_stall                (o_stall),
    .o_busy                 (o_busy),
    .o_valid                (o_valid),
    .o_reg_write            (o_reg_write),
    .o_register_address     (o_register_address),
    .o_alu_result           (o_alu_result),
    .o_memory_data          (o_memory_data)
  );

  typedef struct {
    string       nm;
    logic [4:0]  addr;
    logic        regw;
    logic        chk;
    logic [31:0] res;
    logic [31:0] mem;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: an output register loads at an edge only if hold was low before it
  initial begin : monitor
    bit   upd;
    exp_t e;
    upd = 1'b0;
    forever begin
      @(negedge clk);
      if (upd && o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: actual=%h required=none", o_alu_result);
        end else begin
          e = sb.pop_front();
          check({e.nm, "_addr"}, {27'd0, o_register_address}, {27'd0, e.addr});
          check({e.nm, "_regw"}, {31'd0, o_reg_write}, {31'd0, e.regw});
          check({e.nm, "_mem"},  o_memory_data, e.mem);
          if (e.chk) check({e.nm, "_res"}, o_alu_result, e.res);
        end
      end
      upd = !hold && rst_n;
    end
  end

  // Present one instruction (rt=9, rd=3, reg_write=1), wait out stalls, queue expectation
  task automatic send(input string nm, input logic [2:0] m, input logic [2:0] ao,
                      input logic s_sh, input logic s_dst, input logic s_src,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                      input logic [31:0] exp, output int stalls);
    exp_t e;
    logic arith;
    md = m; aop = ao; sh = s_sh; dst = s_dst; src = s_src;
    ra = a; rb = b; imm = im; rt = 5'd9; rd = 5'd3; regw = 1'b1; vld = 1'b1;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!o_stall) break;
      stalls++;
      if (stalls >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: actual=stalled required=accepted", nm);
        break;
      end
    end
    arith  = (m >= c_MD_MULT) && (m <= c_MD_DIVU);
    e.nm   = nm;
    e.addr = ((m == c_MD_MFHI) || (m == c_MD_MFLO) || !s_dst) ? 5'd3 : 5'd9;
    e.regw = !arith;
    e.chk  = !arith;
    e.res  = exp;
    e.mem  = b;
    sb.push_back(e);
    @(posedge clk);
    #1 vld = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int st;
    rst_n = 1'b0; vld = 1'b0; hold = 1'b0; md = c_MD_NONE; aop = c_AOP_RTYPE;
    sh = 1'b0; dst = 1'b0; src = 1'b0; regw = 1'b0; ra = '0; rb = '0; imm = '0; rt = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_regw",  {31'd0, o_reg_write}, 32'd0);
    check("rst_addr",  {27'd0, o_register_address}, 32'd0);
    check("rst_res",   o_alu_result, 32'd0);
    check("rst_mem",   o_memory_data, 32'd0);
    @(posedge clk);
    #1;

    // Plain ALU paths
    send("add", c_MD_NONE, c_AOP_RTYPE, 0, 0, 0, 32'd5, 32'd7, 32'h20, 32'd12, st);
    send("sub", c_MD_NONE, c_AOP_RTYPE, 0, 0, 0, 32'd5, 32'd7, 32'h22, 32'hFFFF_FFFE, st);
    send("ori", c_MD_NONE, c_AOP_OR,    0, 1, 1, 32'h0F, 32'h55, 32'hF0, 32'hFF, st);
    send("sll", c_MD_NONE, c_AOP_RTYPE, 1, 0, 0, 32'd0, 32'd3, 32'h100, 32'h30, st);

    // Multiply / divide through HI/LO
    send("mult_a", c_MD_MULT, c_AOP_RTYPE, 0, 0, 0, 32'hFFFF_FFFD, 32'd7, 32'h20, 32'd0, st);
    send("mflo_a", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd1, 32'h20, 32'hFFFF_FFEB, st);
    check("mflo_a_stalls", st, 32'd32);
    send("mfhi_a", c_MD_MFHI, c_AOP_RTYPE, 0, 1, 0, 32'd0, 32'd2, 32'h20, 32'hFFFF_FFFF, st);
    send("multu", c_MD_MULTU, c_AOP_RTYPE, 0, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'h20, 32'd0, st);
    send("mfhi_u", c_MD_MFHI, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd3, 32'h20, 32'd1, st);
    send("mflo_u", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd4, 32'h20, 32'hFFFF_FFFE, st);
    send("divu", c_MD_DIVU, c_AOP_RTYPE, 0, 0, 0, 32'd100, 32'd7, 32'h20, 32'd0, st);
    send("mflo_du", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd5, 32'h20, 32'd14, st);
    send("mfhi_du", c_MD_MFHI, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd6, 32'h20, 32'd2, st);
    send("div", c_MD_DIV, c_AOP_RTYPE, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'h20, 32'd0, st);
    send("mflo_d", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd7, 32'h20, 32'hFFFF_FFFD, st);
    send("mfhi_d", c_MD_MFHI, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd8, 32'h20, 32'hFFFF_FFFF, st);
    send("div0", c_MD_DIV, c_AOP_RTYPE, 0, 0, 0, 32'd9, 32'd0, 32'h20, 32'd0, st);
    send("mfhi_z", c_MD_MFHI, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd9, 32'h20, 32'd9, st);
    send("mflo_z", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd10, 32'h20, 32'hFFFF_FFFF, st);

    // Stall the cycle after MULT, then an ALU op slipping through a busy unit
    send("mult_b", c_MD_MULT, c_AOP_RTYPE, 0, 0, 0, 32'd6, 32'd7, 32'h20, 32'd0, st);
    send("mflo_b", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd11, 32'h20, 32'd42, st);
    check("mflo_b_stalls", st, 32'd32);
    send("multu_c", c_MD_MULTU, c_AOP_RTYPE, 0, 0, 0, 32'd3, 32'd5, 32'h20, 32'd0, st);
    check("busy_during_add", {31'd0, o_busy}, 32'd1);
    send("add_busy", c_MD_NONE, c_AOP_RTYPE, 0, 0, 0, 32'd1, 32'd1, 32'h20, 32'd2, st);
    check("add_busy_stalls", st, 32'd0);
    send("mflo_c", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd12, 32'h20, 32'd15, st);
    check("mflo_c_stalls", st, 32'd31);

    // Reset on the 10th busy cycle aborts the multiply
    send("mult_r", c_MD_MULT, c_AOP_RTYPE, 0, 0, 0, 32'd11, 32'd13, 32'h20, 32'd0, st);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("busy_before_rst", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_addr",  {27'd0, o_register_address}, 32'd0);
    check("midrst_res",   o_alu_result, 32'd0);
    check("midrst_mem",   o_memory_data, 32'd0);
    send("mflo_r", c_MD_MFLO, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd13, 32'h20, 32'd0, st);
    check("mflo_r_stalls", st, 32'd0);
    send("mfhi_r", c_MD_MFHI, c_AOP_RTYPE, 0, 0, 0, 32'd0, 32'd14, 32'h20, 32'd0, st);

    // Hold freezes the EX/MEM register while a SUB waits at the input
    send("add_h", c_MD_NONE, c_AOP_RTYPE, 0, 0, 0, 32'd1, 32'd2, 32'h20, 32'd3, st);
    md = c_MD_NONE; aop = c_AOP_RTYPE; sh = 1'b0; dst = 1'b1; src = 1'b0;
    ra = 32'd10; rb = 32'd4; imm = 32'h22; vld = 1'b1; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, o_valid}, 32'd1);
      check("hold_res",   o_alu_result, 32'd3);
      check("hold_addr",  {27'd0, o_register_address}, 32'd3);
      check("hold_mem",   o_memory_data, 32'd2);
    end
    hold = 1'b0;
    send("sub_h", c_MD_NONE, c_AOP_RTYPE, 0, 1, 0, 32'd10, 32'd4, 32'h22, 32'd6, st);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execution_md.md
# execution_md

Parametrised successor to the combinational execution stage. Adds a registered EX/MEM output boundary, a downstream hold, and an iterative multiply/divide unit with HI/LO registers. The ALU datapath is unchanged: destination select, shamt/immediate operand muxing, alu_control, alu. The block sits between ID/EX and the memory stage and stalls the front end while multiply/divide work is pending.

## Interface
Parameters:
- NB_DATA, 32, datapath width; must be even and ≥ 8.
- NB_REG_ADDRESS, 5, register index width.
- NB_OP_FIELD, 6, funct field width.
- NB_ALU_OP_FIELD, 3, alu_operation width.
- NB_MD_OP, 3, multiply/divide operation width.

Ports:
- i_clock, in, 1, single clock; all state updates on the rising edge.
- i_reset, in, 1, synchronous, active-low reset.
- i_valid, in, 1, the ID/EX slot holds an instruction.
- i_hold, in, 1, downstream hold; freezes all output registers.
- i_shift_source, i_register_destination, i_alu_source, in, 1 each, operand and destination selects; same meaning as the existing stage.
- i_alu_operation, in, NB_ALU_OP_FIELD, ALU class.
- i_md_operation, in, NB_MD_OP, encodings: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO.
- i_reg_write, in, 1, writeback enable, passed through.
- i_ra_data, i_rb_data, i_sign_extender_data, in, NB_DATA each, operands and immediate.
- i_rt_address, i_rd_address, in, NB_REG_ADDRESS each, candidate destinations.
- o_stall, out, 1, instruction not accepted this cycle; upstream holds.
- o_busy, out, 1, multiply/divide in progress.
- o_valid, out, 1, registered result valid.
- o_reg_write, out, 1, registered writeback enable.
- o_register_address, out, NB_REG_ADDRESS, registered destination.
- o_alu_result, out, NB_DATA, registered result.
- o_memory_data, out, NB_DATA, registered rb data.

## Operation
- Acceptance: accept = i_valid & ~o_stall & ~i_hold.
- o_stall = o_busy & i_valid & (i_md_operation != NONE). Plain ALU ops proceed while the unit is busy.
- NONE: result is the ALU output. Destination is rt when i_register_destination=1, else rd. The shift operand is {zeros, imm[10:6]}.
- MFHI/MFLO: the result is HI/LO, the destination is rd, and o_reg_write passes through.
- MULT/MULTU/DIV/DIVU:
  - Accepted only when idle.
  - Captured operands are rs and rt.
  - o_reg_write is forced to 0.
  - o_valid=1 (the slot retires).
- Multiply: shift-add over the operand magnitudes. Signed ops take absolute values at start and apply the sign to the 2·NB_DATA product at finish. HI holds the upper half, LO the lower.
- Divide: restoring, on magnitudes.
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
  - LO receives the quotient, HI the remainder.
- Divide by zero: HI = dividend, LO = all ones. Full iteration count, no hang.
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL/DIV on accepted op; counter loads NB_DATA.
  - Each cycle: counter decrements.
  - At count 1: HI/LO written, return to IDLE.
- The FSM ignores i_hold; HI/LO updates cannot be held.
- Reset: all output registers, HI, LO and the counter go to 0; FSM to IDLE; o_busy=0. Reset mid-operation aborts with no HI/LO write.

## Timing
- ALU/MFHI/MFLO latency is one cycle: accept at cycle T, outputs valid in cycle T+1.
- A cycle with no accept loads o_valid=0.
- i_hold=1 keeps every output register at its prior value.
- Multiply/divide:
  - Accept at T.
  - o_busy=1 during T+1 … T+NB_DATA.
  - HI/LO written at the edge ending T+NB_DATA.
  - o_busy=0 at T+NB_DATA+1.
- An MFHI/MFLO or multiply/divide presented during busy stalls. It is accepted in cycle T+NB_DATA+1 and sees the new HI/LO.
- o_stall and o_busy are combinational from state plus inputs, with no register delay. o_busy=0 out of reset.

## Structure
- Package execution_pkg holds:
  - the md op encodings;
  - the FSM state enum (IDLE, MUL, DIV);
  - the divide-by-zero LO constant.
- Reused as-is: alu_control, alu.
- New sub-module muldiv_iterative holds the FSM, counter, sign fix, and HI/LO. The top keeps the muxes and the EX/MEM register.

## Test plan
- ADD funct with ra=5, rb=7 -> o_alu_result=12, o_valid=1, next cycle.
- MULT −3×7, then MFLO and MFHI after idle -> LO=0xFFFFFFEB, HI=0xFFFFFFFF; MULTU 0xFFFFFFFF×2 -> HI=1, LO=0xFFFFFFFE.
- DIVU 100/7 -> LO=14, HI=2; DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 9/0 -> HI=9, LO=0xFFFFFFFF.
- MFLO presented the cycle after MULT 6×7 -> o_stall high 32 cycles, then o_alu_result=42; an interleaved ADD during busy completes unstalled.
- Reset low on the 10th busy cycle of MULT -> next cycle all outputs 0, o_busy=0, MFLO returns 0.
- i_hold=1 for 3 cycles after an ADD -> outputs constant, no instruction accepted, o_valid unchanged.
